btn_event_sched: RTL and testbench

- Schedules the one-cycle button pulses produced by the board's debounce/edge-detect stage onto one shared event consumer (menu FSM, display controller).
- Latches each pulse as a pending event and arbitrates among the 4 channels, round-robin.
- Presents one event at a time on a valid/ready interface.
- Counts events lost because a channel pulsed again before its previous event was scheduled.

---
 rtl/btn_event_sched.sv | 196 +++++++++++++++++++
 tb/tb_btn_event_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_sched.sv
// -----------------------------------------------------------------------------
// btn_event_sched
//
// Collects one-cycle button pulses from the debounce/edge-detect stage into a
// pending vector and hands them, one at a time, to a single event consumer
// over a valid/ready interface. Arbitration is round-robin by default.
//
// Build option:
//   BTN_SCHED_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                         no last-grant register.
//                            undefined -> round-robin, search starts at
//                                         last_grant+1 and wraps.
//   Drop counting, latency and handshake behave the same in both builds.
//
// Ports:
//   cclk       in   system clock, rising edge
//   clr        in   asynchronous active-high reset
//   pulse_in   in   [NBTN]   one-cycle event pulses, bit i = button i
//   evt_ready  in   consumer accepts the offered event
//   evt_valid  out  event offered
//   evt_id     out  [IDW]    index of the offered button
//   pending    out  [NBTN]   latched events not yet loaded into the offer
//   drop_cnt   out  [DROP_W] saturating count of cycles with >=1 drop
//   drop_flag  out  sticky drop indicator, cleared only by clr
//   dbg_state  out  FSM state (0 = IDLE, 1 = OFFER)
//
// Handshake: an event transfers on a rising edge where evt_valid and
// evt_ready are both 1. While evt_valid=1 and evt_ready=0, evt_id and
// evt_valid hold. evt_ready is ignored when evt_valid=0. All outputs are
// registered; evt_ready has no combinational path to evt_valid/evt_id.
// -----------------------------------------------------------------------------
module btn_event_sched #(
  parameter int NBTN   = 4,
  parameter int IDW    = 2,
  parameter int DROP_W = 8
) (
  input  logic              cclk,
  input  logic              clr,
  input  logic [NBTN-1:0]   pulse_in,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [IDW-1:0]    evt_id,
  output logic [NBTN-1:0]   pending,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              drop_flag,
  output logic              dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic            load;      // a pending event moves into the offer this cycle
  logic [IDW-1:0]  grant;     // winner among registered pending bits
  logic            any_pend;
  logic [NBTN-1:0] sel;       // one-hot of grant, qualified by load
  logic            drop_any;

  assign any_pend  = |pending;
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Arbitration. Only the registered pending vector takes part; a pulse that
  // arrives this cycle is not visible until next cycle.
  // ---------------------------------------------------------------------------
`ifdef BTN_SCHED_FIXED_PRIO_EN

  always_comb begin
    grant = '0;
    // Scan from the top so the lowest set index is the last one written.
    for (int k = NBTN - 1; k >= 0; k--) begin
      if (pending[k]) begin
        grant = k[IDW-1:0];
      end
    end
  end

`else

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] rr_idx;
  logic           rr_found;

  always_comb begin
    grant    = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    // NBTN is a power of two equal to 2**IDW, so the IDW-bit add wraps
    // modulo NBTN without an explicit compare.
    for (int k = 1; k <= NBTN; k++) begin
      rr_idx = last_grant + k[IDW-1:0];
      if (!rr_found && pending[rr_idx]) begin
        grant    = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      // Reset to the top index so channel 0 is searched first.
      last_grant <= IDW'(NBTN - 1);
    end else if (load) begin
      last_grant <= grant;
    end
  end

`endif

  // ---------------------------------------------------------------------------
  // FSM: next state and load decision.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          load     = 1'b1;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          if (any_pend) begin
            // Back-to-back: the accepted slot is refilled on the same edge.
            load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    sel = '0;
    if (load) begin
      sel[grant] = 1'b1;
    end
  end

  // A pulse on a bit being loaded this cycle is a fresh event, not a drop.
  assign drop_any = |(pulse_in & pending & ~sel);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      evt_valid <= (state_nx == OFFER);
      if (load) begin
        evt_id <= grant;
      end
    end
  end

  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~sel) | pulse_in;
    end
  end

  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      drop_cnt  <= '0;
      drop_flag <= 1'b0;
    end else if (drop_any) begin
      drop_flag <= 1'b1;
      if (drop_cnt != {DROP_W{1'b1}}) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_btn_event_sched.sv
// -----------------------------------------------------------------------------
// tb_btn_event_sched
//
// Directed scenarios followed by randomized pulse/ready traffic. A behavioural
// reference model (bit array of pending events, one offer slot, arithmetic
// round-robin search) predicts every output each cycle; accepted event ids are
// additionally checked through an expected queue.
// -----------------------------------------------------------------------------
module tb_btn_event_sched;

  localparam int NBTN   = 4;
  localparam int IDW    = 2;
  localparam int DROP_W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              cclk = 1'b0;
  logic              clr  = 1'b1;
  logic [NBTN-1:0]   pulse_in = '0;
  logic              evt_ready = 1'b0;
  logic              evt_valid;
  logic [IDW-1:0]    evt_id;
  logic [NBTN-1:0]   pending;
  logic [DROP_W-1:0] drop_cnt;
  logic              drop_flag;
  logic              dbg_state;

  always #5 cclk = ~cclk;

  btn_event_sched #(
    .NBTN  (NBTN),
    .IDW   (IDW),
    .DROP_W(DROP_W)
  ) dut (
    .cclk     (cclk),
    .clr      (clr),
    .pulse_in (pulse_in),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .pending  (pending),
    .drop_cnt (drop_cnt),
    .drop_flag(drop_flag),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [IDW-1:0] exp_q[$];

  // Reference model
  logic [NBTN-1:0] m_pend;
  bit              m_valid;
  int              m_id;
  int              m_lg;
  int              m_drop;
  bit              m_flag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 0;
    m_id    = 0;
    m_lg    = NBTN - 1;
    m_drop  = 0;
    m_flag  = 0;
    exp_q.delete();
  endtask

  // One clock of the specification's rules, given this cycle's inputs.
  task automatic model_step(input logic [NBTN-1:0] p, input logic r);
    int  w;
    int  c;
    bit  drop;
    w = -1;
    if (m_pend != 0 && (!m_valid || r)) begin
`ifdef BTN_SCHED_FIXED_PRIO_EN
      for (int i = 0; i < NBTN; i++) begin
        if (w < 0 && m_pend[i]) w = i;
      end
`else
      for (int k = 1; k <= NBTN; k++) begin
        c = (m_lg + k) % NBTN;
        if (w < 0 && m_pend[c]) w = c;
      end
`endif
    end
    if (m_valid && r) exp_q.push_back(m_id[IDW-1:0]);
    drop = 0;
    for (int i = 0; i < NBTN; i++) begin
      if (p[i] && m_pend[i] && w != i) drop = 1;
    end
    for (int i = 0; i < NBTN; i++) begin
      m_pend[i] = (m_pend[i] && w != i) || p[i];
    end
    if (w >= 0) begin
      m_id    = w;
      m_valid = 1;
      m_lg    = w;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    if (drop) begin
      if (m_drop < (1 << DROP_W) - 1) m_drop++;
      m_flag = 1;
    end
  endtask

  task automatic compare_all();
    check("evt_valid", 32'(evt_valid), 32'(m_valid));
    check("evt_id",    32'(evt_id),    32'(m_id));
    check("pending",   32'(pending),   32'(m_pend));
    check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    check("drop_flag", 32'(drop_flag), 32'(m_flag));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks. Entered and left at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input logic [NBTN-1:0] p, input logic r);
    pulse_in  = p;
    evt_ready = r;
    model_step(p, r);
    if (evt_valid && r) begin
      if (exp_q.size() > 0) check("accept_id", 32'(evt_id), 32'(exp_q.pop_front()));
      else                  check("accept_unexpected", 32'(evt_valid), 32'd0);
    end
    @(posedge cclk);
    @(negedge cclk);
    compare_all();
  endtask

  task automatic apply_reset();
    pulse_in  = '0;
    evt_ready = 1'b0;
    #1 clr = 1'b1;
    #1;
    // Asynchronous: outputs must already be cleared before any clock edge.
    check("rst_valid",   32'(evt_valid), 32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_drop",    32'(drop_cnt),  32'd0);
    check("rst_flag",    32'(drop_flag), 32'd0);
    model_reset();
    @(negedge cclk);
    clr = 1'b0;
    compare_all();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [NBTN-1:0] rp;
    logic            rr;

    model_reset();
    repeat (2) @(negedge cclk);
    clr = 1'b0;
    compare_all();

    // Single event: pending at t+1, offer at t+2, gone at t+3.
    tick(4'b0100, 1'b1);
    check("single_pend", 32'(pending), 32'b0100);
    tick(4'b0000, 1'b1);
    check("single_valid", 32'(evt_valid), 32'd1);
    check("single_id",    32'(evt_id),    32'd2);
    tick(4'b0000, 1'b1);
    check("single_done", 32'(evt_valid), 32'd0);

    // Round-robin burst then 1001 (same order in the fixed-priority build).
    apply_reset();
    tick(4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(4'b0000, 1'b1);
      check("rr_valid", 32'(evt_valid), 32'd1);
      check("rr_id",    32'(evt_id),    32'(i));
    end
    tick(4'b0000, 1'b1);
    check("rr_idle", 32'(evt_valid), 32'd0);
    tick(4'b1001, 1'b1);
    tick(4'b0000, 1'b1);
    check("rr2_id0", 32'(evt_id), 32'd0);
    tick(4'b0000, 1'b1);
    check("rr2_id3", 32'(evt_id), 32'd3);
    tick(4'b0000, 1'b1);

    // Backpressure and drop.
    apply_reset();
    tick(4'b0001, 1'b0);
    tick(4'b0000, 1'b0);
    check("bp_valid", 32'(evt_valid), 32'd1);
    check("bp_id",    32'(evt_id),    32'd0);
    tick(4'b0000, 1'b0);
    tick(4'b0001, 1'b0);
    check("bp_repend", 32'(pending),  32'b0001);
    check("bp_nodrop", 32'(drop_cnt), 32'd0);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b0001, 1'b0);
    check("bp_drop_cnt",  32'(drop_cnt),  32'd1);
    check("bp_drop_flag", 32'(drop_flag), 32'd1);
    check("bp_hold_id",   32'(evt_id),    32'd0);
    check("bp_hold_vld",  32'(evt_valid), 32'd1);

    // Saturation.
    for (int i = 0; i < 300; i++) tick(4'b0001, 1'b0);
    check("sat_cnt", 32'(drop_cnt), 32'd255);

    // Simultaneous pulse on the channel being selected.
    apply_reset();
    tick(4'b0010, 1'b0);
    tick(4'b0010, 1'b0);
    check("sim_nodrop", 32'(drop_cnt), 32'd0);
    check("sim_pend",   32'(pending),  32'b0010);
    check("sim_id",     32'(evt_id),   32'd1);
    tick(4'b0000, 1'b1);
    check("sim_again_vld", 32'(evt_valid), 32'd1);
    check("sim_again_id",  32'(evt_id),    32'd1);
    tick(4'b0000, 1'b1);

    // Reset while offering with pending=1010.
    apply_reset();
    tick(4'b0010, 1'b0);
    tick(4'b1010, 1'b0);
    check("mid_pend",  32'(pending),   32'b1010);
    check("mid_valid", 32'(evt_valid), 32'd1);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, 1'b1);
      check("post_rst_quiet", 32'(evt_valid), 32'd0);
    end

    // Randomized traffic.
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      rp = ($urandom_range(0, 2) == 0) ? NBTN'($urandom_range(0, 15)) : '0;
      rr = ($urandom_range(0, 3) != 0);
      tick(rp, rr);
    end
    for (int i = 0; i < 8; i++) tick(4'b0000, 1'b1);
    check("drain_q", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
